// File: rtl/edge_event_serializer.sv
// Collects per-switch edge pulses into a pending set and presents them one at a time,
// lowest index first, over a valid/ready handshake, counting edges lost to re-triggering.
module edge_event_serializer #(
   parameter int unsigned NUM_BITS = 18,
   localparam int unsigned IDX_W = $clog2(NUM_BITS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BITS-1:0] SW_edge_det,
   input  logic [NUM_BITS-1:0] SW_level,
   input  logic                event_ready,
   input  logic                ovf_clr,
   output logic                event_valid,
   output logic [IDX_W-1:0]    event_index,
   output logic                event_level,
   output logic                overflow,
   output logic [7:0]          drop_count,
   output logic                busy
);

   typedef enum logic [0:0] {StIdle, StPresent} state_e;

   state_e              r_state, w_state_next;
   logic [NUM_BITS-1:0] r_pending, w_pending_next;
   logic [IDX_W-1:0]    r_index, w_index_next;
   logic                r_level, w_level_next;
   logic                r_ovf, w_ovf_next;
   logic [7:0]          r_drop, w_drop_next;

   logic [IDX_W-1:0]    w_sel_idx;
   logic                w_load;
   logic [NUM_BITS-1:0] w_load_mask;
   logic [NUM_BITS-1:0] w_drop_vec;
   logic [15:0]         w_drop_num;
   logic [15:0]         w_drop_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_pending <= '0;
         r_index   <= '0;
         r_level   <= 1'b0;
         r_ovf     <= 1'b0;
         r_drop    <= 8'd0;
      end else begin
         r_state   <= w_state_next;
         r_pending <= w_pending_next;
         r_index   <= w_index_next;
         r_level   <= w_level_next;
         r_ovf     <= w_ovf_next;
         r_drop    <= w_drop_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_level_next = r_level;
      w_sel_idx    = '0;
      w_drop_num   = 16'd0;

      // Descending scan so the lowest set bit is the last one written.
      for (int i = NUM_BITS - 1; i >= 0; i--) begin
         if (r_pending[i]) w_sel_idx = IDX_W'(i);
      end

      w_load      = (|r_pending) && ((r_state == StIdle) || event_ready);
      w_load_mask = w_load ? (NUM_BITS'(1) << w_sel_idx) : '0;

      // A pulse on the bit being loaded re-arms it rather than counting as lost.
      w_drop_vec     = SW_edge_det & r_pending & ~w_load_mask;
      w_pending_next = (r_pending & ~w_load_mask) | SW_edge_det;

      for (int i = 0; i < NUM_BITS; i++) begin
         w_drop_num = w_drop_num + 16'(w_drop_vec[i]);
      end
      w_drop_sum  = (ovf_clr ? 16'd0 : {8'd0, r_drop}) + w_drop_num;
      w_drop_next = (w_drop_sum > 16'd255) ? 8'hFF : w_drop_sum[7:0];
      w_ovf_next  = (|w_drop_vec) | (r_ovf & ~ovf_clr);

      if (w_load) begin
         w_state_next = StPresent;
         w_index_next = w_sel_idx;
         w_level_next = SW_level[w_sel_idx];
      end else if ((r_state == StPresent) && event_ready) begin
         w_state_next = StIdle;
      end
   end

   assign event_valid = (r_state == StPresent);
   assign event_index = r_index;
   assign event_level = r_level;
   assign overflow    = r_ovf;
   assign drop_count  = r_drop;
   assign busy        = (|r_pending) | event_valid;

endmodule

// File: doc/edge_event_serializer.md
EDGE_EVENT_SERIALIZER -- requirements
Module: edge_event_serializer

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 18: width of the per-switch edge-pulse and level vectors.
REQ-002 The block SHALL have localparam IDX_W = $clog2(NUM_BITS), default 5: width of the event index.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input SW_edge_det, NUM_BITS: per-bit edge pulses; bit i high for one cycle = one change on switch i.
REQ-006 The block SHALL have input SW_level, NUM_BITS: current (synchronised) switch levels, used to report edge direction.
REQ-007 The block SHALL have input event_ready, 1 bit: consumer accepts the presented event.
REQ-008 The block SHALL have input ovf_clr, 1 bit: synchronous clear of the overflow flag and drop counter.
REQ-009 The block SHALL have output event_valid, 1 bit: an event is presented.
REQ-010 The block SHALL have output event_index, IDX_W bits: switch number of the presented event.
REQ-011 The block SHALL have output event_level, 1 bit: switch level at load time (1 = rising, 0 = falling).
REQ-012 The block SHALL have output overflow, 1 bit: sticky flag, an edge was lost.
REQ-013 The block SHALL have output drop_count, 8 bits: saturating count of lost edges.
REQ-014 The block SHALL have output busy, 1 bit: equals (|pending) | event_valid.

Function
REQ-015 The block SHALL hold a NUM_BITS pending register; bit i is set at the clock edge where SW_edge_det[i]=1.
REQ-016 The block SHALL be a two-state machine: IDLE (event_valid=0) and PRESENT (event_valid=1).
REQ-017 A load SHALL occur when (IDLE or (PRESENT and event_ready)) and pending is non-zero.
REQ-018 A load SHALL select the lowest set pending index, register it on event_index, register SW_level[index] on event_level, clear that pending bit, and enter or stay in PRESENT.
REQ-019 In PRESENT with event_ready=1 and pending=0, the block SHALL return to IDLE.
REQ-020 In PRESENT with event_ready=0, event_index and event_level SHALL hold unchanged.
REQ-021 Selection SHALL use only the registered pending value; an edge pulse in cycle N makes event_valid high no earlier than cycle N+2 (latency 2 from an idle block).
REQ-022 Back-to-back events SHALL be delivered one per cycle while event_ready=1 and pending is non-zero.
REQ-023 If SW_edge_det[i]=1 in the same cycle bit i is loaded, pending[i] SHALL remain set, and this is not an overflow.
REQ-024 If SW_edge_det[i]=1 while pending[i]=1 and bit i is not loaded that cycle, the edge SHALL be dropped: overflow set, drop_count incremented.
REQ-025 drop_count SHALL add the number of dropped bits in a cycle, saturating at 255.
REQ-026 If ovf_clr=1, overflow and drop_count SHALL clear; a drop in the same cycle SHALL win (overflow=1, drop_count = that cycle's drops).
REQ-027 When IDLE, event_index and event_level SHALL hold their last values.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force pending=0, IDLE state, event_valid=0, event_index=0, event_level=0, overflow=0, drop_count=0, busy=0.
REQ-029 Reset asserted mid-handshake SHALL discard the presented event and all pending events; none are replayed after release.
REQ-030 After rst_n deasserts, the first event SHALL be loaded no earlier than the second rising clk.

Verification
REQ-031 Single edge: SW_edge_det=0x00004, SW_level[2]=1 for 1 cycle, event_ready=1 -> two cycles later event_valid=1 for exactly 1 cycle, event_index=2, event_level=1.
REQ-032 Priority and burst: SW_edge_det=0x20011 for 1 cycle, event_ready=1 -> events with index 0, 4, 17 on consecutive cycles, then event_valid=0.
REQ-033 Backpressure: same as REQ-032 with event_ready=0 for 5 cycles -> index 0 held stable for 5 cycles; then 0, 4, 17 are delivered, with no overflow.
REQ-034 Overflow: event_ready=0, two pulses on bit 3 while it is pending -> overflow=1, drop_count=1; ovf_clr pulse -> both are 0.
REQ-035 Reset mid-operation: rst_n=0 while event_valid=1 with 3 events pending -> all outputs are 0 immediately and no events appear after release without new edges.
REQ-036 Set/load collision: pulse on bit 5 in the cycle bit 5 is loaded -> bit 5 is delivered twice, with overflow=0.
